ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist.sv | 140 ++++++++++++++
 tb/tb_ram_bist.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March-style RAM self test: write/read a pattern, then write/read its inverse.
// Read data is compared one cycle after each read request against an
// expected value held in a single pipeline stage.
//
// state | meaning
// IDLE  | waiting for start, results held
// WR0   | write E0(a) = PATTERN ^ a to every address
// RD0   | read back every address, then one drain cycle
// WR1   | write E1(a) = ~E0(a) to every address
// RD1   | read back every address, then one drain cycle
// FIN   | one-cycle done pulse, pass valid
module ram_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FIN} state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(2**ADDR_W - 1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt;        // extra MSB marks the read drain cycle
  logic              last_wr;
  logic              drain;
  logic              inv_phase;
  logic [DATA_W-1:0] exp_cur;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_vld;
  logic              mismatch;
  logic [7:0]        err_nxt;

  function automatic logic [DATA_W-1:0] e0(input logic [ADDR_W-1:0] a);
    return PATTERN ^ DATA_W'(a);
  endfunction

  assign last_wr   = (cnt == LAST);
  assign drain     = cnt[ADDR_W];
  assign inv_phase = (state == WR1) || (state == RD1);
  assign exp_cur   = inv_phase ? ~e0(cnt[ADDR_W-1:0]) : e0(cnt[ADDR_W-1:0]);
  assign mismatch  = rd_vld && (ram_dout != exp_q);
  assign err_nxt   = (mismatch && err_count != 8'hFF) ? err_count + 8'd1 : err_count;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and RAM strobes
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = WR0;
      WR0, WR1: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cnt[ADDR_W-1:0];
        ram_din  = exp_cur;
        if (last_wr) state_nxt = (state == WR0) ? RD0 : RD1;
      end
      RD0, RD1: begin
        busy = 1'b1;
        if (!drain) begin
          ram_re   = 1'b1;
          ram_addr = cnt[ADDR_W-1:0];
        end else begin
          state_nxt = (state == RD0) ? WR1 : FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // address counter, compare pipeline and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rd_vld    <= 1'b0;
      exp_q     <= '0;
      addr_q    <= '0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      pass      <= 1'b0;
    end else begin
      rd_vld <= ram_re;
      exp_q  <= exp_cur;
      addr_q <= cnt[ADDR_W-1:0];
      case (state)
        WR0, WR1: cnt <= last_wr ? '0 : cnt + 1'b1;
        RD0, RD1: cnt <= drain ? '0 : cnt + 1'b1;
        default:  cnt <= '0;
      endcase
      if (state == IDLE && start) begin
        err_count <= '0;
        fail_addr <= '0;
        fail_data <= '0;
        pass      <= 1'b0;
      end else begin
        if (mismatch) begin
          err_count <= err_nxt;
          if (err_count == 8'd0) begin
            fail_addr <= addr_q;
            fail_data <= ram_dout;
          end
        end
        // the drain-cycle compare is folded in through err_nxt
        if (state == RD1 && drain) pass <= (err_nxt == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a 16x8 registered-read RAM model that can
// inject stuck-bit, stuck-address-line and all-zero read faults. Completed
// runs are checked by a scoreboard monitor that pops an expected result on
// every done pulse.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ram_we, ram_re;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] fail_addr;
  logic [7:0] fail_data;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [1:0] mode = 2'd0;   // 0 healthy, 1 addr5 bit0 stuck-1, 2 addr line 3 stuck-0, 3 reads 0
  logic [7:0] mem [16];

  typedef struct {
    bit         p;
    logic [7:0] e;
    logic [3:0] fa;
    logic [7:0] fd;
    int         c;
  } exp_t;
  exp_t sbq[$];

  ram_bist #(.ADDR_W(4), .DATA_W(8), .PATTERN(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with fault injection
  always @(posedge clk) begin
    logic [3:0] a;
    a = (mode == 2'd2) ? (ram_addr & 4'h7) : ram_addr;
    if (ram_we) mem[a] <= ram_din;
    if (ram_re) begin
      if (mode == 2'd3)                         ram_dout <= 8'h00;
      else if (mode == 2'd1 && ram_addr == 4'd5) ram_dout <= mem[a] | 8'h01;
      else                                      ram_dout <= mem[a];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ram_we && ram_re) check("we_re_exclusive", 1, 0);
      if (done) begin
        if (sbq.size() == 0) begin
          check("stray_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("done_cycle", cyc, e.c);
          check("pass", pass, e.p);
          check("err_count", err_count, e.e);
          check("fail_addr", fail_addr, e.fa);
          check("fail_data", fail_data, e.fd);
          check("busy_in_fin", busy, 0);
        end
      end
    end
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    s = cyc;
  endtask

  task automatic push(input bit p, input logic [7:0] e, input logic [3:0] fa,
                      input logic [7:0] fd, input int s);
    exp_t x;
    x.p = p; x.e = e; x.fa = fa; x.fd = fd; x.c = s + 66;
    sbq.push_back(x);
  endtask

  // wait for done (bounded); optionally check the two writes to address 3
  task automatic run_wait(input bit wr3);
    int k = 0;
    int nw = 0;
    while (!done && k < 150) begin
      if (wr3 && ram_we && ram_addr == 4'd3) begin
        check("wr_addr3", ram_din, (nw == 0) ? 8'hA6 : 8'h59);
        nw++;
      end
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
    if (wr3) check("wr_addr3_count", nw, 2);
    @(negedge clk);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst   = 1'b1;
    start = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, done, pass, err_count, fail_addr, fail_data, ram_we, ram_re, ram_addr, ram_din}, 0);
    start = 1'b1;                      // rst must win over start
    @(negedge clk);
    check("rst_over_start_busy", busy, 0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    // healthy RAM
    mode = 2'd0;
    pulse_start(s);
    push(1'b1, 8'd0, 4'd0, 8'h00, s);
    run_wait(1'b1);

    // second start while busy is ignored; pass drops during the run
    pulse_start(s);
    push(1'b1, 8'd0, 4'd0, 8'h00, s);
    repeat (9) @(negedge clk);
    check("pass_low_busy", pass, 0);
    check("busy_mid", busy, 1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    run_wait(1'b0);
    repeat (10) @(negedge clk);
    check("hold_pass", pass, 1);
    check("hold_err", err_count, 0);
    check("idle_busy", busy, 0);

    // addr 5 bit 0 stuck at 1
    mode = 2'd1;
    pulse_start(s);
    push(1'b0, 8'd1, 4'd5, 8'hA1, s);
    run_wait(1'b0);

    // address line 3 stuck at 0
    mode = 2'd2;
    pulse_start(s);
    push(1'b0, 8'd16, 4'd0, 8'hAD, s);
    run_wait(1'b0);
    check("hold_fail_data", fail_data, 8'hAD);

    // reset in RD0 aborts the run with no done pulse
    mode = 2'd0;
    pulse_start(s);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_re", ram_re, 0);
    check("abort_pass", pass, 0);
    check("abort_err", err_count, 0);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    pulse_start(s);
    push(1'b1, 8'd0, 4'd0, 8'h00, s);
    run_wait(1'b0);

    // every read mismatches; two back-to-back runs
    mode = 2'd3;
    pulse_start(s);
    push(1'b0, 8'd32, 4'd0, 8'h00, s);
    run_wait(1'b0);
    pulse_start(s);
    push(1'b0, 8'd32, 4'd0, 8'h00, s);
    run_wait(1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
